// File: rtl/zelda_pkg.sv
// Shared definitions for the levelmap collision path: screen geometry,
// direction codes, mover request record and scheduler state encoding.
package zelda_pkg;

    localparam int SCREEN_W   = 320;
    localparam int SCREEN_H   = 240;
    localparam int MAP_ADDR_W = 17;
    localparam int X_W        = 9;
    localparam int Y_W        = 8;
    localparam int DIR_W      = 3;

    typedef enum logic [DIR_W-1:0] {
        DIR_NO_ACTION = 3'd0,
        DIR_ATTACK    = 3'd1,
        DIR_UP        = 3'd2,
        DIR_DOWN      = 3'd3,
        DIR_LEFT      = 3'd4,
        DIR_RIGHT     = 3'd5
    } dir_e;

    // Position and intent of one mover, captured at arbitration time.
    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [DIR_W-1:0] dir;
    } mover_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } cms_state_e;

    // Linear levelmap address; the 17-bit product wraps by construction.
    function automatic logic [MAP_ADDR_W-1:0] map_addr(input logic [X_W-1:0] x,
                                                      input logic [Y_W-1:0] y);
        return MAP_ADDR_W'(y) * MAP_ADDR_W'(SCREEN_W) + MAP_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/collision_corner_gen.sv
// Combinational corner generator: displaces a mover's top-left point by one
// move step and selects one of the four box corners, producing the ROM
// address and an off-screen flag.
// Optional feature macro: COLLISION_BOUNDS_CHECK_EN (off-screen detection);
// without it out_of_bounds is tied low and wrapped addresses go to the ROM.
module collision_corner_gen
    import zelda_pkg::*;
#(
    parameter int BOX  = 16,
    parameter int STEP = 1
) (
    input  logic [X_W-1:0]        x,
    input  logic [Y_W-1:0]        y,
    input  logic [DIR_W-1:0]      dir,
    input  logic [1:0]            k,
    output logic [X_W-1:0]        corner_x,
    output logic [Y_W-1:0]        corner_y,
    output logic [MAP_ADDR_W-1:0] rom_addr,
    output logic                  out_of_bounds
);

    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;

    // Step offset for the requested direction; non-move codes probe in place.
    always_comb begin
        dx = '0;
        dy = '0;
        case (dir)
            DIR_UP:    dy = Y_W'(-STEP);
            DIR_DOWN:  dy = Y_W'(STEP);
            DIR_LEFT:  dx = X_W'(-STEP);
            DIR_RIGHT: dx = X_W'(STEP);
            default:   ;
        endcase
    end

    // k[0] selects the right edge, k[1] the bottom edge; sums wrap naturally.
    always_comb begin
        corner_x = x + dx + (k[0] ? X_W'(BOX) : '0);
        corner_y = y + dy + (k[1] ? Y_W'(BOX) : '0);
        rom_addr = map_addr(corner_x, corner_y);
`ifdef COLLISION_BOUNDS_CHECK_EN
        out_of_bounds = (corner_x > X_W'(SCREEN_W - 1)) || (corner_y > Y_W'(SCREEN_H - 1));
`else
        out_of_bounds = 1'b0;
`endif
    end

endmodule

// File: rtl/collision_map_scheduler.sv
// Round-robin scheduler sharing one single-port levelmap ROM among N_REQ
// movers. Each served mover gets its four displaced box corners probed and a
// per-mover blocked result with a one-cycle done pulse.
// Optional feature macro: COLLISION_BOUNDS_CHECK_EN (off-screen corners block).
module collision_map_scheduler
    import zelda_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int BOX   = 16,
    parameter int STEP  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [X_W*N_REQ-1:0]    req_x,
    input  logic [Y_W*N_REQ-1:0]    req_y,
    input  logic [DIR_W*N_REQ-1:0]  req_dir,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        blocked,
    output logic                    busy,
    output logic [MAP_ADDR_W-1:0]   rom_addr,
    input  logic                    rom_q
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    cms_state_e      state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, win_idx, cur_idx;
    logic             grant;
    mover_req_t       sel_req, cur_req, gen_req;
    logic [1:0]       k, gen_k;
    logic             acc;
    logic             addr_oob;   // off-screen flag of the address on rom_addr
    logic             data_oob;   // same flag, aligned with rom_q
    logic [MAP_ADDR_W-1:0] gen_addr;
    logic             gen_oob;
    // Probe coordinates are only needed for debug visibility.
    logic [X_W+Y_W-1:0] corner_unused;

    // Round-robin pick: first requester strictly after rr_ptr, wrapping.
    always_comb begin
        grant   = 1'b0;
        win_idx = rr_ptr;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!grant && req[IDX_W'((int'(rr_ptr) + i) % N_REQ)]) begin
                grant   = 1'b1;
                win_idx = IDX_W'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    // Slice the winner's fields out of the packed request buses.
    always_comb begin
        sel_req.x   = req_x[win_idx*X_W +: X_W];
        sel_req.y   = req_y[win_idx*Y_W +: Y_W];
        sel_req.dir = req_dir[win_idx*DIR_W +: DIR_W];
    end

    // Corner 0 is generated from live inputs during IDLE so its address is
    // registered on the same edge that latches the request; later corners
    // come from the latched copy one index ahead of k.
    always_comb begin
        gen_req = (state == ST_IDLE) ? sel_req : cur_req;
        gen_k   = (state == ST_IDLE) ? 2'd0 : k + 2'd1;
    end

    collision_corner_gen #(
        .BOX  (BOX),
        .STEP (STEP)
    ) u_corner (
        .x             (gen_req.x),
        .y             (gen_req.y),
        .dir           (gen_req.dir),
        .k             (gen_k),
        .corner_x      (corner_unused[X_W+Y_W-1:Y_W]),
        .corner_y      (corner_unused[Y_W-1:0]),
        .rom_addr      (gen_addr),
        .out_of_bounds (gen_oob)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: IDLE -> FETCH (4 corners) -> DRAIN -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant) state_nxt = ST_FETCH;
            ST_FETCH: if (k == 2'd3) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Datapath: latch request, walk corner addresses, fold ROM data into acc,
    // publish the result on the winner's done/blocked bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= IDX_W'(N_REQ - 1);
            cur_idx  <= '0;
            cur_req  <= '0;
            k        <= '0;
            acc      <= 1'b1;
            addr_oob <= 1'b0;
            data_oob <= 1'b0;
            rom_addr <= '0;
            done     <= '0;
            blocked  <= '0;
        end else begin
            done     <= '0;
            data_oob <= addr_oob;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        cur_req  <= sel_req;
                        cur_idx  <= win_idx;
                        rr_ptr   <= win_idx;
                        k        <= 2'd0;
                        rom_addr <= gen_addr;
                        addr_oob <= gen_oob;
                    end
                end
                ST_FETCH: begin
                    if (k != 2'd0) acc <= acc & rom_q & ~data_oob;
                    if (k != 2'd3) begin
                        k        <= k + 2'd1;
                        rom_addr <= gen_addr;
                        addr_oob <= gen_oob;
                    end
                end
                ST_DRAIN: acc <= acc & rom_q & ~data_oob;
                ST_DONE: begin
                    done[cur_idx]    <= 1'b1;
                    blocked[cur_idx] <= ~acc;
                    acc              <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_map_scheduler.sv
// Directed bench for collision_map_scheduler with a behavioural levelmap ROM.
module tb_collision_map_scheduler;
    import zelda_pkg::*;

    localparam int N = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [X_W*N-1:0] req_x = '0;
    logic [Y_W*N-1:0] req_y = '0;
    logic [DIR_W*N-1:0] req_dir = '0;
    logic [N-1:0]     done;
    logic [N-1:0]     blocked;
    logic             busy;
    logic [MAP_ADDR_W-1:0] rom_addr;
    logic             rom_q = 1'b1;

    logic rom_mem [0:131071];

    int checks = 0;
    int errors = 0;

    collision_map_scheduler #(.N_REQ(N), .BOX(16), .STEP(1)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_x    (req_x),
        .req_y    (req_y),
        .req_dir  (req_dir),
        .done     (done),
        .blocked  (blocked),
        .busy     (busy),
        .rom_addr (rom_addr),
        .rom_q    (rom_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_q <= rom_mem[rom_addr];

    task automatic rom_fill_walkable();
        for (int a = 0; a < 131072; a++) rom_mem[a] = 1'b1;
    endtask

    task automatic set_mover(input int idx, input int x, input int y, input int dir);
        req_x[idx*X_W +: X_W]       = X_W'(x);
        req_y[idx*Y_W +: Y_W]       = Y_W'(y);
        req_dir[idx*DIR_W +: DIR_W] = DIR_W'(dir);
    endtask

    // Clocks until a done pulse (bounded), recording the first four rom_addr values.
    task automatic wait_done(output int cycles, output logic [3:0][16:0] addrs,
                             output logic [N-1:0] seen);
        cycles = 0;
        seen   = '0;
        addrs  = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            cycles = c;
            if (c <= 4) addrs[c-1] = rom_addr;
            if (done != '0) begin
                seen = done;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", done); end
        checks++; if (blocked !== 2'b00) begin errors++; $display("FAIL reset_blocked: got %b expected 00", blocked); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rom_addr !== 17'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy: got %b expected 0", busy); end
    endtask

    task automatic test_up_walkable();
        int cyc;
        logic [3:0][16:0] a;
        logic [N-1:0] s;
        int exp_a [4] = '{31780, 31796, 36900, 36916};
        set_mover(0, 100, 100, DIR_UP);
        req = 2'b01;
        wait_done(cyc, a, s);
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a[i] !== 17'(exp_a[i])) begin errors++; $display("FAIL up_addr%0d: got %0d expected %0d", i, a[i], exp_a[i]); end
        end
        checks++; if (cyc !== 7) begin errors++; $display("FAIL up_latency: got %0d expected 7", cyc); end
        checks++; if (s !== 2'b01) begin errors++; $display("FAIL up_done: got %b expected 01", s); end
        checks++; if (blocked !== 2'b00) begin errors++; $display("FAIL up_blocked: got %b expected 00", blocked); end
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0 || done !== 2'b00) begin errors++; $display("FAIL up_after: busy %b done %b expected 0 00", busy, done); end
    endtask

    task automatic test_right_blocked();
        int cyc;
        logic [3:0][16:0] a;
        logic [N-1:0] s;
        int exp_a [4] = '{16101, 16117, 21221, 21237};
        rom_mem[50*320 + 117] = 1'b0;
        set_mover(1, 100, 50, DIR_RIGHT);
        req = 2'b10;
        wait_done(cyc, a, s);
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a[i] !== 17'(exp_a[i])) begin errors++; $display("FAIL right_addr%0d: got %0d expected %0d", i, a[i], exp_a[i]); end
        end
        checks++; if (s !== 2'b10 || cyc !== 7) begin errors++; $display("FAIL right_done: got %b at %0d expected 10 at 7", s, cyc); end
        checks++; if (blocked !== 2'b10) begin errors++; $display("FAIL right_blocked: got %b expected 10", blocked); end
        rom_mem[50*320 + 117] = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int ev_cyc [4];
        logic [N-1:0] ev_val [4];
        int nev = 0;
        int overlap = 0;
        set_mover(0, 100, 100, DIR_NO_ACTION);
        set_mover(1, 200, 100, DIR_NO_ACTION);
        req = 2'b11;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock); #1;
            if (done == 2'b11) overlap++;
            if (done != '0 && nev < 4) begin
                ev_cyc[nev] = c;
                ev_val[nev] = done;
                nev++;
                if (nev == 4) begin
                    req = 2'b00;
                    break;
                end
            end
        end
        req = 2'b00;
        checks++; if (nev !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", nev); end
        for (int i = 0; i < nev; i++) begin
            checks++;
            if (ev_cyc[i] !== 7*(i+1) || ev_val[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10))
            begin errors++; $display("FAIL b2b_event%0d: got %b at %0d expected %b at %0d", i, ev_val[i], ev_cyc[i], (i % 2 == 0) ? 2'b01 : 2'b10, 7*(i+1)); end
        end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_overlap: got %0d expected 0", overlap); end
        checks++; if (blocked !== 2'b00) begin errors++; $display("FAIL b2b_blocked: got %b expected 00", blocked); end
        @(posedge clock); #1;
    endtask

    task automatic test_left_wrap();
        int cyc;
        logic [3:0][16:0] a;
        logic [N-1:0] s;
        logic exp_b;
        int exp_a [4] = '{3711, 3215, 8831, 8335};
`ifdef COLLISION_BOUNDS_CHECK_EN
        exp_b = 1'b1;
`else
        exp_b = 1'b0;
`endif
        set_mover(0, 0, 10, DIR_LEFT);
        req = 2'b01;
        wait_done(cyc, a, s);
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a[i] !== 17'(exp_a[i])) begin errors++; $display("FAIL left_addr%0d: got %0d expected %0d", i, a[i], exp_a[i]); end
        end
        checks++; if (s !== 2'b01 || cyc !== 7) begin errors++; $display("FAIL left_done: got %b at %0d expected 01 at 7", s, cyc); end
        checks++; if (blocked[0] !== exp_b) begin errors++; $display("FAIL left_walkable_blocked: got %b expected %b", blocked[0], exp_b); end
        @(posedge clock); #1;
        // Wrapped corner (511,10) made solid: blocked in either build.
        rom_mem[3711] = 1'b0;
        req = 2'b01;
        wait_done(cyc, a, s);
        req = 2'b00;
        checks++; if (s !== 2'b01 || blocked[0] !== 1'b1) begin errors++; $display("FAIL left_solid_blocked: done %b blocked %b expected 01 1", s, blocked[0]); end
        rom_mem[3711] = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        logic [3:0][16:0] a;
        logic [N-1:0] s;
        int dseen = 0;
        set_mover(0, 100, 100, DIR_UP);
        set_mover(1, 200, 100, DIR_UP);
        req = 2'b01;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (blocked !== 2'b00) begin errors++; $display("FAIL midrst_blocked: got %b expected 00", blocked); end
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            if (done != '0) dseen++;
        end
        checks++; if (dseen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", dseen); end
        req = 2'b11;
        reset = 1'b1;
        wait_done(cyc, a, s);
        req = 2'b00;
        checks++; if (s !== 2'b01 || cyc !== 7) begin errors++; $display("FAIL midrst_first: got %b at %0d expected 01 at 7", s, cyc); end
        @(posedge clock); #1;
    endtask

    task automatic test_attack();
        int cyc;
        logic [3:0][16:0] a;
        logic [N-1:0] s;
        int exp_a [4] = '{12840, 12856, 17960, 17976};
        set_mover(0, 40, 40, DIR_ATTACK);
        req = 2'b01;
        wait_done(cyc, a, s);
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a[i] !== 17'(exp_a[i])) begin errors++; $display("FAIL attack_addr%0d: got %0d expected %0d", i, a[i], exp_a[i]); end
        end
        checks++; if (s !== 2'b01 || blocked[0] !== 1'b0) begin errors++; $display("FAIL attack_done: done %b blocked %b expected 01 0", s, blocked[0]); end
        @(posedge clock); #1;
    endtask

    initial begin
        rom_fill_walkable();
        test_reset();
        test_up_walkable();
        test_right_blocked();
        test_back_to_back();
        test_left_wrap();
        test_reset_mid_op();
        test_attack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
